// File: rtl/digit_serial_abs_diff.sv
// Digit-serial |A - B| engine: one 2-bit borrow-chained subtract per clock, followed
// by a digit-serial two's-complement pass when the raw difference comes out negative.
module digit_serial_abs_diff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             negFlag,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_a_nx;
  logic [WIDTH-1:0] op_b, op_b_nx;
  logic [WIDTH-1:0] diff, diff_nx;
  logic             chain, chain_nx;
  logic [CW-1:0]    count, count_nx;
  logic [WIDTH-1:0] result_nx;
  logic             neg_nx;
  logic [2:0]       sub_sum;
  logic [2:0]       neg_sum;
  logic             last;

  // New digit enters at the MSB end while the accumulated digits move toward the LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [1:0] d, input logic [WIDTH-1:0] v);
    logic [WIDTH+1:0] t;
    t = {d, v};
    return t[WIDTH+1:2];
  endfunction

  // chain is the borrow during SUB and the increment carry during NEG
  assign sub_sum = {1'b0, op_a[1:0]} - {1'b0, op_b[1:0]} - {2'b00, chain};
  assign neg_sum = {1'b0, ~diff[1:0]} + {2'b00, chain};
  assign last    = (count == LAST_DIGIT);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nx  = state;
    op_a_nx   = op_a;
    op_b_nx   = op_b;
    diff_nx   = diff;
    chain_nx  = chain;
    count_nx  = count;
    result_nx = result;
    neg_nx    = negFlag;
    case (state)
      IDLE: begin
        if (start) begin
          op_a_nx  = A;
          op_b_nx  = B;
          diff_nx  = '0;
          chain_nx = 1'b0;
          count_nx = '0;
          state_nx = SUB;
        end
      end
      SUB: begin
        op_a_nx  = op_a >> 2;
        op_b_nx  = op_b >> 2;
        diff_nx  = shift_in(sub_sum[1:0], diff);
        chain_nx = sub_sum[2];
        count_nx = count + CW'(1);
        if (last) begin
          if (sub_sum[2]) begin
            // Raw difference is negative: negate it digit by digit (~x + 1)
            state_nx = NEG;
            count_nx = '0;
            chain_nx = 1'b1;
          end else begin
            state_nx  = DONE;
            result_nx = shift_in(sub_sum[1:0], diff);
            neg_nx    = 1'b0;
          end
        end
      end
      NEG: begin
        diff_nx  = shift_in(neg_sum[1:0], diff);
        chain_nx = neg_sum[2];
        count_nx = count + CW'(1);
        if (last) begin
          state_nx  = DONE;
          result_nx = shift_in(neg_sum[1:0], diff);
          neg_nx    = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      diff    <= '0;
      chain   <= 1'b0;
      count   <= '0;
      result  <= '0;
      negFlag <= 1'b0;
    end else begin
      state   <= state_nx;
      op_a    <= op_a_nx;
      op_b    <= op_b_nx;
      diff    <= diff_nx;
      chain   <= chain_nx;
      count   <= count_nx;
      result  <= result_nx;
      negFlag <= neg_nx;
    end
  end

endmodule

// File: tb/tb_digit_serial_abs_diff.sv
// Directed and swept checks of digit_serial_abs_diff: result/negFlag, latency,
// handshake timing, ignored starts and asynchronous reset.
module tb_digit_serial_abs_diff;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk;
  logic         rstN;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] result;
  logic         negFlag;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;
  logic [W-1:0] prev_res;
  logic         prev_neg;

  digit_serial_abs_diff #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .A(A), .B(B),
    .result(result), .negFlag(negFlag), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_neg;
    int           exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Waits (bounded) for done; called at posedge+1 right after the capture edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 40 && !done) begin
      chk("result_stable", result, prev_res);
      chk("neg_stable", negFlag, prev_neg);
      chk("busy_during_op", busy, 1);
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic finish_op(input string nm, input logic [W-1:0] er, input logic en,
                           input int el, input int cyc);
    chk({nm, "_latency"}, cyc, el);
    chk({nm, "_result"}, result, er);
    chk({nm, "_neg"}, negFlag, en);
    chk({nm, "_busy_in_done"}, busy, 1);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_result_held"}, result, er);
    prev_res = er;
    prev_neg = en;
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic en, input int el);
    int cyc;
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    wait_done(cyc);
    finish_op(nm, er, en, el, cyc);
  endtask

  vec_t vecs[9];

  initial begin
    int cyc;
    logic [W-1:0] ra, rb;
    n_checks = 0; n_fail = 0;
    prev_res = '0; prev_neg = 1'b0;
    rstN = 1'b0; start = 1'b0; A = '0; B = '0;

    vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0, N};
    vecs[1] = '{8'd55,  8'd200, 8'd145, 1'b1, 2*N};
    vecs[2] = '{8'hAA,  8'hAA,  8'd0,   1'b0, N};
    vecs[3] = '{8'd0,   8'd255, 8'd255, 1'b1, 2*N};
    vecs[4] = '{8'd255, 8'd0,   8'd255, 1'b0, N};
    vecs[5] = '{8'd128, 8'd127, 8'd1,   1'b0, N};
    vecs[6] = '{8'd127, 8'd128, 8'd1,   1'b1, 2*N};
    vecs[7] = '{8'd16,  8'd1,   8'd15,  1'b0, N};
    vecs[8] = '{8'd3,   8'd252, 8'd249, 1'b1, 2*N};

    #3;
    chk("reset_result", result, 0);
    chk("reset_neg", negFlag, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("idle_without_start", busy, 0);

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_res,
            vecs[i].exp_neg, vecs[i].exp_lat);

    // Starts during SUB and DONE are ignored; start in first IDLE cycle is taken
    start = 1'b1; A = 8'd10; B = 8'd3;
    @(posedge clk); #1;
    A = 8'd1; B = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 40 && !done) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_latency", cyc, N);
    chk("ign_result", result, 7);
    chk("ign_neg", negFlag, 0);
    start = 1'b1; A = 8'd1; B = 8'd2;
    @(posedge clk); #1;
    chk("ign_idle_after_done", busy, 0);
    chk("ign_result_kept", result, 7);
    prev_res = 8'd7; prev_neg = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    finish_op("first_idle_start", 8'd1, 1'b1, 2*N, cyc);

    // Asynchronous reset in the middle of the NEG pass
    start = 1'b1; A = 8'd9; B = 8'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 2) @(posedge clk);
    #2;
    chk("pre_reset_busy", busy, 1);
    rstN = 1'b0;
    #1;
    chk("areset_result", result, 0);
    chk("areset_neg", negFlag, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    cyc = 0;
    repeat (2 * N + 2) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    rstN = 1'b1;
    repeat (2 * N) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    chk("aborted_no_done", cyc, 0);
    prev_res = '0; prev_neg = 1'b0;
    do_op("after_reset", 8'd100, 8'd9, 8'd91, 1'b0, N);

    // Random sweep against a reference model
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      do_op("sweep", ra, rb, (ra >= rb) ? ra - rb : rb - ra, ra < rb,
            (ra < rb) ? 2 * N : N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_serial_abs_diff.md
Name: digit_serial_abs_diff

Overview:
Sequential absolute-difference engine. It computes |A - B| for unsigned WIDTH-bit operands, two bits per clock, using a borrow-chained 2-bit subtract stage. This is the subtract-direction counterpart of the 2-bit mux-based adder slice. If the raw difference is negative, a second digit-serial pass two's-complements it. The block sits in the AbsDiff datapath behind a start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2. N = WIDTH/2 digits.

Ports:
clk  input  1  rising-edge clock
rstN  input  1  reset; asynchronous, active-low
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend, unsigned; captured on accepted start
B  input  WIDTH  subtrahend, unsigned; captured on accepted start
result  output  WIDTH  |A - B|, registered; held until the next completion
negFlag  output  1  1 when A < B, registered alongside result
busy  output  1  high in SUB, NEG and DONE states
done  output  1  one-cycle completion pulse (high in DONE state)

Behaviour:
- States: IDLE, SUB, NEG, DONE. Digit counter runs 0..N-1.
- Reset (rstN low, asynchronous): state=IDLE, result=0, negFlag=0, busy=0, done=0, internal shift regs/borrow/count=0. Takes effect immediately, including mid-operation. The aborted operation produces no done.
- IDLE: on an edge with start=1, load opA<=A, opB<=B, diff<=0, borrow<=0, count<=0, and go to SUB. If start=0, stay.
- SUB, each edge:
  - {b_out, d[1:0]} = opA[1:0] - opB[1:0] - borrow (2-bit subtract with borrow-in; b_out=1 when the result is negative).
  - Shift opA and opB right by 2.
  - diff <= {d, diff[WIDTH-1:2]}; borrow <= b_out; count++.
  - On the edge with count==N-1:
    - If final b_out=1: go to NEG with count<=0 and carry<=1.
    - Otherwise: go to DONE, result<=final diff, negFlag<=0.
- NEG, each edge:
  - {c_out, n[1:0]} = ~diff[1:0] + carry.
  - diff <= {n, diff[WIDTH-1:2]}; carry <= c_out; count++.
  - On the edge with count==N-1: go to DONE, result<=final diff, negFlag<=1.
- DONE: done=1 for exactly one cycle, busy=1; next edge returns to IDLE. start is ignored in this cycle.
- Latency: capture edge = edge 0.
  - A >= B: done high in the cycle after edge N.
  - A < B: done high in the cycle after edge 2N.
  - Next start can be accepted on the edge that leaves DONE+1, i.e. the first IDLE cycle.
- start while busy: ignored. A and B are not re-sampled, and the operation in flight is unaffected.
- Width rule: |A - B| of two unsigned WIDTH-bit values always fits in WIDTH bits, so there is no overflow output.
- Boundary values:
  - A==B: result 0, negFlag 0, no NEG pass.
  - A=0, B=2^WIDTH-1: result 2^WIDTH-1, negFlag 1.
- result and negFlag change only on the transition into DONE or on reset. They are stable at all other times.
- A and B may change freely after the capture edge.

Test Plan:
1. WIDTH=8, A=200, B=55, start 1 cycle -> done pulse 4 cycles after capture; result=145, negFlag=0; busy high for 5 cycles.
2. A=55, B=200 -> done 8 cycles after capture; result=145, negFlag=1; NEG state visited for 4 cycles.
3. A=B=0xAA -> result=0, negFlag=0, done after 4 cycles. Then A=0, B=255 -> result=255, negFlag=1. Then A=255, B=0 -> result=255, negFlag=0.
4. Start A=10, B=3, then assert start again with A=1, B=2 during SUB and during DONE -> both ignored; result=7. Start asserted in the first IDLE cycle after done is accepted: A=1, B=2 -> result=1, negFlag=1.
5. Start A=9, B=100; pull rstN low asynchronously (between clock edges) during NEG -> result, negFlag, busy, done go to 0 immediately; no done pulse. After release, A=100, B=9 -> result=91, negFlag=0.
6. Random sweep of 1000 operand pairs against a reference model, checking |A-B|, negFlag = (A<B), latency N or 2N, and a single done per accepted start.
